// File: rtl/counter_sweep_pkg.sv
// Shared definitions for the sweep sequencer: mode encodings and FSM states.
package counter_sweep_pkg;

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_PING = 2'b10;
    localparam logic [1:0] MODE_WRAP = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/updown_count_core.sv
// Loadable up/down count register; load wins over enable, value holds otherwise.
module updown_count_core #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             en,
    input  logic             load,
    input  logic             up_downN,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= up_downN ? count + WIDTH'(1) : count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sweep sequencer: loads an origin, steps toward an end bound at a prescaled rate,
// then stops, bounces or reloads according to the captured mode.
module counter_sweep_ctrl
    import counter_sweep_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [1:0]       mode,
    input  logic [PRE_W-1:0] prescale,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             dir,
    output logic             step,
    output logic             wrap,
    output logic             done,
    output logic             err
);

    state_t             state, state_n;
    logic [PRE_W-1:0]   pre_cnt, pre_cnt_n;
    logic [WIDTH-1:0]   lo_q, hi_q;
    logic [1:0]         mode_q;
    logic [PRE_W-1:0]   pre_q;
    logic               dir_n, busy_n, step_n, wrap_n, done_n, err_n;
    logic               capture;
    logic               core_en, core_load, core_up;
    logic [WIDTH-1:0]   core_val, end_val;

    updown_count_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .resetN   (resetN),
        .en       (core_en),
        .load     (core_load),
        .up_downN (core_up),
        .load_val (core_val),
        .count    (count)
    );

    always_comb begin
        state_n   = state;
        pre_cnt_n = pre_cnt;
        dir_n     = dir;
        step_n    = 1'b0;
        wrap_n    = 1'b0;
        done_n    = 1'b0;
        err_n     = 1'b0;
        capture   = 1'b0;
        core_en   = 1'b0;
        core_load = 1'b0;
        core_up   = dir;
        core_val  = lo;
        end_val   = dir ? hi_q : lo_q;

        if (abort) begin
            state_n   = IDLE;
            pre_cnt_n = '0;
        end else if (state == IDLE) begin
            if (start) begin
                if (lo <= hi) begin
                    capture   = 1'b1;
                    pre_cnt_n = '0;
                    state_n   = RUN;
                    core_load = 1'b1;
                    if (mode == MODE_DOWN) begin
                        core_val = hi;
                        dir_n    = 1'b0;
                    end else begin
                        core_val = lo;
                        dir_n    = 1'b1;
                    end
                end else begin
                    err_n = 1'b1;
                end
            end
        end else if (pre_cnt != pre_q) begin
            pre_cnt_n = pre_cnt + PRE_W'(1);
        end else begin
            pre_cnt_n = '0;
            if (count != end_val) begin
                core_en = 1'b1;
                step_n  = 1'b1;
            end else begin
                case (mode_q)
                    MODE_UP, MODE_DOWN: begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                    // A degenerate lo == hi range still flips direction and flags the bounce.
                    MODE_PING: begin
                        dir_n  = ~dir;
                        wrap_n = 1'b1;
                        if (lo_q != hi_q) begin
                            core_en = 1'b1;
                            core_up = ~dir;
                            step_n  = 1'b1;
                        end
                    end
                    default: begin
                        core_load = 1'b1;
                        core_val  = lo_q;
                        wrap_n    = 1'b1;
                    end
                endcase
            end
        end

        busy_n = (state_n == RUN);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state   <= IDLE;
            pre_cnt <= '0;
            dir     <= 1'b1;
            busy    <= 1'b0;
            step    <= 1'b0;
            wrap    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            pre_cnt <= pre_cnt_n;
            dir     <= dir_n;
            busy    <= busy_n;
            step    <= step_n;
            wrap    <= wrap_n;
            done    <= done_n;
            err     <= err_n;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            lo_q   <= '0;
            hi_q   <= '0;
            mode_q <= '0;
            pre_q  <= '0;
        end else if (capture) begin
            lo_q   <= lo;
            hi_q   <= hi;
            mode_q <= mode;
            pre_q  <= prescale;
        end
    end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed vector bench for counter_sweep_ctrl: a per-cycle table plus a hand-written
// asynchronous reset sequence.
module tb_counter_sweep_ctrl;

    typedef struct {
        string      name;
        logic       start;
        logic       abort;
        logic [4:0] lo;
        logic [4:0] hi;
        logic [1:0] mode;
        logic [7:0] prescale;
        logic [4:0] exp_count;
        logic       exp_busy;
        logic       exp_dir;
        logic       exp_step;
        logic       exp_wrap;
        logic       exp_done;
        logic       exp_err;
    } vec_t;

    logic       clk;
    logic       resetN;
    logic       start;
    logic       abort;
    logic [4:0] lo;
    logic [4:0] hi;
    logic [1:0] mode;
    logic [7:0] prescale;
    logic [4:0] count;
    logic       busy, dir, step, wrap, done, err;

    int   n_compared;
    int   n_mismatched;
    vec_t vecs[$];

    counter_sweep_ctrl #(.WIDTH(5), .PRE_W(8)) dut (
        .clk      (clk),
        .resetN   (resetN),
        .start    (start),
        .abort    (abort),
        .lo       (lo),
        .hi       (hi),
        .mode     (mode),
        .prescale (prescale),
        .count    (count),
        .busy     (busy),
        .dir      (dir),
        .step     (step),
        .wrap     (wrap),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add_vec(input string n, input logic st, input logic ab,
                                    input logic [4:0] l, input logic [4:0] h,
                                    input logic [1:0] m, input logic [7:0] p,
                                    input logic [4:0] c, input logic b, input logic d,
                                    input logic s, input logic w, input logic dn,
                                    input logic e);
        vec_t v;
        v.name = n;   v.start = st;  v.abort = ab;  v.lo = l;  v.hi = h;
        v.mode = m;   v.prescale = p;
        v.exp_count = c; v.exp_busy = b; v.exp_dir = d; v.exp_step = s;
        v.exp_wrap = w;  v.exp_done = dn; v.exp_err = e;
        vecs.push_back(v);
    endfunction

    task automatic check_output(input string name, input logic [4:0] c, input logic b,
                                input logic d, input logic s, input logic w,
                                input logic dn, input logic e);
        logic [10:0] got, want;
        got  = {count, busy, dir, step, wrap, done, err};
        want = {c, b, d, s, w, dn, e};
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got count=%0d busy=%b dir=%b step=%b wrap=%b done=%b err=%b, expected count=%0d busy=%b dir=%b step=%b wrap=%b done=%b err=%b",
                     name, count, busy, dir, step, wrap, done, err, c, b, d, s, w, dn, e);
        end
    endtask

    task automatic drive(input logic st, input logic ab, input logic [4:0] l,
                         input logic [4:0] h, input logic [1:0] m, input logic [7:0] p);
        start = st; abort = ab; lo = l; hi = h; mode = m; prescale = p;
    endtask

    task automatic apply_stimulus(input vec_t v);
        drive(v.start, v.abort, v.lo, v.hi, v.mode, v.prescale);
        @(posedge clk);
        #1;
        check_output(v.name, v.exp_count, v.exp_busy, v.exp_dir, v.exp_step,
                     v.exp_wrap, v.exp_done, v.exp_err);
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        resetN = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        // name           st ab lo hi md ps   cnt bsy dir stp wrp dne err
        add_vec("idle",      0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0);
        add_vec("up_start",  1, 0, 3, 6, 0, 0,   3, 1, 1, 0, 0, 0, 0);
        add_vec("up_s1",     0, 0, 0,31, 3, 5,   4, 1, 1, 1, 0, 0, 0);
        add_vec("up_s2",     0, 0, 0,31, 3, 5,   5, 1, 1, 1, 0, 0, 0);
        add_vec("up_s3",     0, 0, 0,31, 3, 5,   6, 1, 1, 1, 0, 0, 0);
        add_vec("up_done",   0, 0, 0,31, 3, 5,   6, 0, 1, 0, 0, 1, 0);
        add_vec("dn_start",  1, 0, 1, 4, 1, 1,   4, 1, 0, 0, 0, 0, 0);
        add_vec("dn_hold4",  0, 0, 1, 4, 1, 1,   4, 1, 0, 0, 0, 0, 0);
        add_vec("dn_s3",     0, 0, 1, 4, 1, 1,   3, 1, 0, 1, 0, 0, 0);
        add_vec("dn_runst",  1, 0, 0,31, 0, 0,   3, 1, 0, 0, 0, 0, 0);
        add_vec("dn_s2",     0, 0, 0,31, 0, 0,   2, 1, 0, 1, 0, 0, 0);
        add_vec("dn_hold2",  0, 0, 0,31, 0, 0,   2, 1, 0, 0, 0, 0, 0);
        add_vec("dn_s1",     0, 0, 0,31, 0, 0,   1, 1, 0, 1, 0, 0, 0);
        add_vec("dn_hold1",  0, 0, 0,31, 0, 0,   1, 1, 0, 0, 0, 0, 0);
        add_vec("dn_done",   0, 0, 0,31, 0, 0,   1, 0, 0, 0, 0, 1, 0);
        add_vec("dn_idle",   0, 0, 0,31, 0, 0,   1, 0, 0, 0, 0, 0, 0);
        add_vec("rej",       1, 0,10, 5, 0, 0,   1, 0, 0, 0, 0, 0, 1);
        add_vec("rej_after", 0, 0,10, 5, 0, 0,   1, 0, 0, 0, 0, 0, 0);
        add_vec("pp_start",  1, 0, 0, 2, 2, 0,   0, 1, 1, 0, 0, 0, 0);
        add_vec("pp_1",      0, 0, 0, 2, 2, 0,   1, 1, 1, 1, 0, 0, 0);
        add_vec("pp_2",      0, 0, 0, 2, 2, 0,   2, 1, 1, 1, 0, 0, 0);
        add_vec("pp_bnc_hi", 0, 0, 0, 2, 2, 0,   1, 1, 0, 1, 1, 0, 0);
        add_vec("pp_0",      0, 0, 0, 2, 2, 0,   0, 1, 0, 1, 0, 0, 0);
        add_vec("pp_bnc_lo", 0, 0, 0, 2, 2, 0,   1, 1, 1, 1, 1, 0, 0);
        add_vec("pp_2b",     0, 0, 0, 2, 2, 0,   2, 1, 1, 1, 0, 0, 0);
        add_vec("pp_abort",  0, 1, 0, 2, 2, 0,   2, 0, 1, 0, 0, 0, 0);
        add_vec("pp7_start", 1, 0, 7, 7, 2, 1,   7, 1, 1, 0, 0, 0, 0);
        add_vec("pp7_hold",  0, 0, 7, 7, 2, 1,   7, 1, 1, 0, 0, 0, 0);
        add_vec("pp7_wrap1", 0, 0, 7, 7, 2, 1,   7, 1, 0, 0, 1, 0, 0);
        add_vec("pp7_hold2", 0, 0, 7, 7, 2, 1,   7, 1, 0, 0, 0, 0, 0);
        add_vec("pp7_wrap2", 0, 0, 7, 7, 2, 1,   7, 1, 1, 0, 1, 0, 0);
        add_vec("pp7_abort", 0, 1, 7, 7, 2, 1,   7, 0, 1, 0, 0, 0, 0);
        add_vec("wr_start",  1, 0,29,31, 3, 0,  29, 1, 1, 0, 0, 0, 0);
        add_vec("wr_30",     0, 0,29,31, 3, 0,  30, 1, 1, 1, 0, 0, 0);
        add_vec("wr_31",     0, 0,29,31, 3, 0,  31, 1, 1, 1, 0, 0, 0);
        add_vec("wr_reload", 0, 0,29,31, 3, 0,  29, 1, 1, 0, 1, 0, 0);
        add_vec("wr_30b",    0, 0,29,31, 3, 0,  30, 1, 1, 1, 0, 0, 0);
        add_vec("wr_ab_run", 1, 1,29,31, 3, 0,  30, 0, 1, 0, 0, 0, 0);
        add_vec("wr_ab_idl", 1, 1,29,31, 3, 0,  30, 0, 1, 0, 0, 0, 0);
        add_vec("wr_idle",   0, 0,29,31, 3, 0,  30, 0, 1, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check_output("reset_state", 0, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) apply_stimulus(vecs[i]);

        // Reset mid-sweep: start on edge s, count 2 -> 3 at s+4 -> 4 at s+8.
        drive(1, 0, 2, 9, 0, 3);
        @(posedge clk);
        #1;
        check_output("rst_start", 2, 1, 1, 0, 0, 0, 0);
        drive(0, 0, 2, 9, 0, 3);
        repeat (9) @(posedge clk);
        #1;
        check_output("rst_cycle10", 4, 1, 1, 0, 0, 0, 0);
        #2;
        resetN = 1'b0;
        #1;
        check_output("rst_async", 0, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        resetN = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check_output("rst_quiet", 0, 0, 1, 0, 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/counter_sweep_ctrl.md
# counter_sweep_ctrl

Programmable sweep sequencer wrapped around a loadable 5-bit up/down count register. It loads a start point on request, steps the count toward an end point at a prescaled rate, and then stops, bounces or reloads according to a mode. It sits between a software/config interface (start/abort, bounds, mode, rate) and any consumer of a timed index, such as a PWM duty stepper or an address sweeper.

## Interface
- WIDTH, 5, count and bound width
- PRE_W, 8, prescaler width
- clk  in  1  rising-edge clock
- resetN  in  1  asynchronous, active-low reset
- start  in  1  request sweep; sampled only in IDLE
- abort  in  1  synchronous stop from any state
- lo  in  WIDTH  lower bound; captured on accepted start
- hi  in  WIDTH  upper bound; captured on accepted start
- mode  in  2  00 single-up, 01 single-down, 10 ping-pong repeat, 11 wrap repeat
- prescale  in  PRE_W  one step every prescale+1 cycles; captured on accepted start
- count  out  WIDTH  current count (registered)
- busy  out  1  high while in RUN
- dir  out  1  1 = counting up, 0 = counting down
- step  out  1  one-cycle pulse when count changes by ±1
- wrap  out  1  one-cycle pulse on bounce (mode 10) or reload (mode 11)
- done  out  1  one-cycle pulse on completion of a single-shot mode
- err  out  1  one-cycle pulse when start is rejected

## Operation
- States: IDLE, RUN.
- Reset: state = IDLE; count = 0, busy = 0, dir = 1, step/wrap/done/err = 0; prescaler = 0; captured bounds, mode and prescale = 0.
- Accepted start means IDLE, start = 1, abort = 0 and lo ≤ hi. On that edge:
  - capture lo, hi, mode and prescale; prescaler ← 0; state → RUN; busy ← 1.
  - Origin: count ← hi, dir ← 0 for mode 01; count ← lo, dir ← 1 otherwise.
- Rejected start: start in IDLE with lo > hi. Then err ← 1 for one cycle; stay in IDLE; count is unchanged.
- start while in RUN is ignored.
- RUN, each cycle:
  - If prescaler ≠ captured prescale, prescaler increments.
  - Otherwise this is a tick: prescaler ← 0, then:
    - count ≠ end (end = hi if dir = 1, else lo): count ± 1 per dir; step ← 1.
    - count = end, mode 00/01: state → IDLE; busy ← 0; done ← 1; count held.
    - count = end, mode 10: dir flips; count moves one toward the new end; step ← 1 and wrap ← 1. If lo = hi, count stays, step = 0 and wrap = 1.
    - count = end, mode 11: count ← lo; wrap ← 1; step = 0.
- abort (any state): state → IDLE; busy ← 0; prescaler ← 0; count and dir held; no done.
- abort has priority over start and over a tick in the same cycle.
- Count arithmetic is modulo 2^WIDTH. Bounds guarantee no wrap-around occurs in normal operation.
- Inputs lo, hi, mode and prescale may change while in RUN without effect.

## Timing
- All outputs are registered. There is no combinational input-to-output path.
- The origin is visible on count one cycle after the accepted start edge.
- Steps occur every prescale+1 cycles.
- Single-shot modes: done is high for exactly one cycle, (|hi−lo|+1)·(prescale+1) edges after the start edge. busy falls on the same edge.
- A new start is accepted on the cycle done is high. The count register is reloaded from the new origin.
- Reset asserted mid-sweep immediately forces the reset values, asynchronously.

## Structure
- Shared package counter_sweep_pkg holds:
  - mode encoding constants MODE_UP, MODE_DOWN, MODE_PING, MODE_WRAP;
  - state enum IDLE/RUN.
- One sub-module, updown_count_core, is the count register:
  - inputs clk, resetN, en, load, up_downN, load_val;
  - load has priority over en;
  - holds its value when en = 0.
- counter_sweep_ctrl contains the FSM, the prescaler, bound capture and pulse generation.

## Test plan
- Reset mid-sweep: mode 00, lo=2, hi=9, prescale=3. Assert resetN low at cycle 10 → count=0, busy=0 immediately; after release, no output activity until start.
- Single-up: lo=3, hi=6, prescale=0 → count 3,4,5,6 on consecutive cycles; done pulse 4 cycles after start; 3 step pulses; busy low with done.
- Single-down with prescale: mode 01, lo=1, hi=4, prescale=1 → count 4,3,2,1, each held 2 cycles; done 8 cycles after start.
- Ping-pong: mode 10, lo=0, hi=2 → count 0,1,2,1,0,1…; wrap at count 2 and at count 0. Second run with lo=hi=7 → count stays 7, wrap every tick, step never.
- Wrap-repeat plus abort: mode 11, lo=29, hi=31 → count 29,30,31,29; wrap on each reload. Assert abort together with start → IDLE, count held, no done.
- Rejected start: lo=10, hi=5 → err pulse one cycle, busy stays 0, count unchanged. A start during RUN is ignored, with no change to the captured bounds.
